// File: rtl/audio_pkg.sv
// Shared constants, FSM encoding and sample-deviation helper for the audio level meter.
package audio_pkg;

    localparam int unsigned NUM_CH    = 4;
    localparam int unsigned SAMPLE_W  = 12;
    localparam int unsigned LEVEL_W   = 12;
    localparam logic [11:0] LEVEL_MAX = 12'd2047;

    localparam logic [0:0] ST_ACCUM  = 1'b0;
    localparam logic [0:0] ST_UPDATE = 1'b1;

    // |data - mid| computed at 13 bits, then clamped to the 11-bit display range.
    function automatic logic [11:0] abs_dev(input logic [11:0] data, input logic [11:0] mid);
        logic [12:0] a;
        logic [12:0] b;
        logic [12:0] diff;
        a    = {1'b0, data};
        b    = {1'b0, mid};
        diff = (a >= b) ? (a - b) : (b - a);
        return (diff > {1'b0, LEVEL_MAX}) ? LEVEL_MAX : diff[11:0];
    endfunction

endpackage

// File: rtl/level_decay.sv
// Per-channel display update: the larger of the new frame peak and the decayed old level.
module level_decay
    import audio_pkg::*;
#(
    parameter int unsigned DECAY_SHIFT = 4
) (
    input  logic [11:0] i_snap,
    input  logic [11:0] i_disp,
    output logic [11:0] o_level
);

    logic [11:0] w_fall;
    logic [11:0] w_decayed;

    // w_fall never exceeds i_disp, so the subtraction cannot wrap.
    assign w_fall    = i_disp >> DECAY_SHIFT;
    assign w_decayed = i_disp - w_fall;
    assign o_level   = (i_snap > w_decayed) ? i_snap : w_decayed;

endmodule

// File: rtl/level_meter.sv
// Four-channel peak level meter: accumulates per-frame peaks and updates decaying display levels.
module level_meter
    import audio_pkg::*;
#(
    parameter int unsigned DECAY_SHIFT = 4,
    parameter int unsigned MIDSCALE    = 2048
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sample_valid,
    input  logic [1:0]  sample_ch,
    input  logic [11:0] sample_data,
    input  logic        frame_start,
    input  logic [1:0]  channel_select,
    output logic [11:0] val,
    output logic        busy
);

    localparam logic [11:0] MID = MIDSCALE[11:0];

    logic [11:0] r_peak [NUM_CH];
    logic [11:0] r_snap [NUM_CH];
    logic [11:0] r_disp [NUM_CH];
    logic [0:0]  r_state;
    logic [1:0]  r_idx;
    logic        r_busy;
    logic [11:0] r_val;

    logic [11:0] w_dev;
    logic        w_take;
    logic [11:0] w_level;

    assign w_dev  = abs_dev(sample_data, MID);
    assign w_take = frame_start && (r_state == ST_ACCUM);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_peak[i] <= '0;
                r_snap[i] <= '0;
            end
        end else begin
            if (w_take) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    r_snap[i] <= r_peak[i];
                    r_peak[i] <= '0;
                end
            end
            // A sample in the snapshot cycle seeds the freshly cleared peak.
            if (sample_valid) begin
                if (w_take) begin
                    r_peak[sample_ch] <= w_dev;
                end else if (w_dev > r_peak[sample_ch]) begin
                    r_peak[sample_ch] <= w_dev;
                end
            end
        end
    end

    level_decay #(
        .DECAY_SHIFT(DECAY_SHIFT)
    ) u_decay (
        .i_snap (r_snap[r_idx]),
        .i_disp (r_disp[r_idx]),
        .o_level(w_level)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_ACCUM;
            r_idx   <= '0;
            r_busy  <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_disp[i] <= '0;
            end
        end else if (r_state == ST_ACCUM) begin
            if (frame_start) begin
                r_state <= ST_UPDATE;
                r_idx   <= '0;
                r_busy  <= 1'b1;
            end
        end else begin
            r_disp[r_idx] <= w_level;
            r_idx         <= r_idx + 2'd1;
            if (r_idx == 2'd3) begin
                r_state <= ST_ACCUM;
                r_busy  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_val <= '0;
        end else begin
            r_val <= r_disp[channel_select];
        end
    end

    assign val  = r_val;
    assign busy = r_busy;

endmodule

// File: tb/tb_level_meter.sv
// Self-checking bench for level_meter: directed vectors, corner sequences, randomized model check.
module tb_level_meter;

    logic        clk;
    logic        rst;
    logic        sample_valid;
    logic [1:0]  sample_ch;
    logic [11:0] sample_data;
    logic        frame_start;
    logic [1:0]  channel_select;
    logic [11:0] val;
    logic        busy;

    int n_pass;
    int n_total;

    level_meter #(
        .DECAY_SHIFT(4),
        .MIDSCALE   (2048)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .sample_valid  (sample_valid),
        .sample_ch     (sample_ch),
        .sample_data   (sample_data),
        .frame_start   (frame_start),
        .channel_select(channel_select),
        .val           (val),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [1:0]  ch;
        logic [11:0] d;
        logic        fs;
        int          exp_val;
        int          exp_busy;
    } vec_t;

    vec_t tbl [9];

    // Reference model state: levels as plain integers.
    int m_peak [4];
    int m_snap [4];
    int m_disp [4];
    int m_left;
    int m_val;
    int m_busy;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic drive(input logic v, input logic [1:0] ch, input logic [11:0] d,
                         input logic fs);
        sample_valid = v;
        sample_ch    = ch;
        sample_data  = d;
        frame_start  = fs;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 2'd0, 12'd2048, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
    endtask

    function automatic int dev_of(input int d);
        int a;
        a = (d > 2048) ? d - 2048 : 2048 - d;
        return (a > 2047) ? 2047 : a;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            m_peak[i] = 0;
            m_snap[i] = 0;
            m_disp[i] = 0;
        end
        m_left = 0;
        m_val  = 0;
        m_busy = 0;
    endtask

    // Advance the model across one clock edge using the inputs currently applied.
    task automatic model_step();
        int nv;
        int c;
        int dec;
        int dv;
        if (rst) begin
            model_clear();
            return;
        end
        nv = m_disp[channel_select];
        if (m_left > 0) begin
            c   = 4 - m_left;
            dec = m_disp[c] - m_disp[c] / 16;
            m_disp[c] = (m_snap[c] > dec) ? m_snap[c] : dec;
            m_left--;
        end else if (frame_start) begin
            for (int i = 0; i < 4; i++) begin
                m_snap[i] = m_peak[i];
                m_peak[i] = 0;
            end
            m_left = 4;
        end
        if (sample_valid) begin
            dv = dev_of(int'(sample_data));
            if (dv > m_peak[sample_ch]) m_peak[sample_ch] = dv;
        end
        m_val  = nv;
        m_busy = (m_left > 0) ? 1 : 0;
    endtask

    int busy_cycles;
    int pick;

    initial begin
        n_pass         = 0;
        n_total        = 0;
        rst            = 1'b1;
        sample_valid   = 1'b0;
        sample_ch      = 2'd0;
        sample_data    = 12'd2048;
        frame_start    = 1'b0;
        channel_select = 2'd0;

        // ch0 peak of {1000, 3500, 2048} is 1452, visible two cycles after frame_start.
        tbl[0] = '{1'b1, 2'd0, 12'd1000, 1'b0, 0,    0};
        tbl[1] = '{1'b1, 2'd0, 12'd3500, 1'b0, 0,    0};
        tbl[2] = '{1'b1, 2'd0, 12'd2048, 1'b0, 0,    0};
        tbl[3] = '{1'b0, 2'd0, 12'd2048, 1'b1, 0,    1};
        tbl[4] = '{1'b0, 2'd0, 12'd2048, 1'b0, 0,    1};
        tbl[5] = '{1'b0, 2'd0, 12'd2048, 1'b0, 1452, 1};
        tbl[6] = '{1'b0, 2'd0, 12'd2048, 1'b0, 1452, 1};
        tbl[7] = '{1'b0, 2'd0, 12'd2048, 1'b0, 1452, 0};
        tbl[8] = '{1'b0, 2'd0, 12'd2048, 1'b0, 1452, 0};

        idle(3);
        check("reset_val", int'(val), 0);
        check("reset_busy", int'(busy), 0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].v, tbl[i].ch, tbl[i].d, tbl[i].fs);
            check($sformatf("peak_vec%0d_val", i), int'(val), tbl[i].exp_val);
            check($sformatf("peak_vec%0d_busy", i), int'(busy), tbl[i].exp_busy);
        end

        // Reset in the middle of an update clears everything.
        drive(1'b0, 2'd0, 12'd2048, 1'b1);
        idle(1);
        do_reset();
        check("midupd_rst_val", int'(val), 0);
        check("midupd_rst_busy", int'(busy), 0);
        drive(1'b0, 2'd0, 12'd2048, 1'b1);
        idle(6);
        check("post_rst_frame_val", int'(val), 0);

        // Decay from 1600 on ch1.
        channel_select = 2'd1;
        drive(1'b1, 2'd1, 12'd3648, 1'b0);
        drive(1'b0, 2'd0, 12'd2048, 1'b1);
        idle(6);
        check("decay_load", int'(val), 1600);
        drive(1'b0, 2'd0, 12'd2048, 1'b1);
        idle(6);
        check("decay_1", int'(val), 1500);
        drive(1'b0, 2'd0, 12'd2048, 1'b1);
        idle(6);
        check("decay_2", int'(val), 1407);

        // Clamp at both rails and 1-cycle select latency.
        drive(1'b1, 2'd2, 12'd0, 1'b0);
        drive(1'b1, 2'd3, 12'd4095, 1'b0);
        drive(1'b0, 2'd0, 12'd2048, 1'b1);
        idle(6);
        channel_select = 2'd2;
        idle(1);
        check("clamp_ch2", int'(val), 2047);
        channel_select = 2'd3;
        idle(1);
        check("clamp_ch3", int'(val), 2047);
        channel_select = 2'd0;
        idle(1);
        check("sel_ch0", int'(val), 0);

        // Sample coincident with frame_start belongs to the next frame.
        drive(1'b1, 2'd0, 12'd3000, 1'b1);
        idle(6);
        check("coinc_excluded", int'(val), 0);
        drive(1'b0, 2'd0, 12'd2048, 1'b1);
        idle(6);
        check("coinc_next_frame", int'(val), 952);

        // Second frame_start during UPDATE is ignored: one update, four busy cycles.
        drive(1'b1, 2'd0, 12'd2848, 1'b0);
        busy_cycles = 0;
        drive(1'b0, 2'd0, 12'd2048, 1'b1);
        busy_cycles += int'(busy);
        idle(1);
        busy_cycles += int'(busy);
        drive(1'b0, 2'd0, 12'd2048, 1'b1);
        busy_cycles += int'(busy);
        for (int i = 0; i < 4; i++) begin
            idle(1);
            busy_cycles += int'(busy);
        end
        check("ignored_fs_busy_cycles", busy_cycles, 4);
        idle(2);
        check("ignored_fs_single_update", int'(val), 893);

        // Randomized run against the reference model.
        do_reset();
        model_clear();
        for (int n = 0; n < 4000; n++) begin
            rst          = ($urandom_range(0, 599) == 0);
            sample_valid = $urandom_range(0, 1) == 1;
            sample_ch    = 2'($urandom_range(0, 3));
            pick         = $urandom_range(0, 7);
            sample_data  = (pick == 0) ? 12'd0 : (pick == 1) ? 12'd4095
                                                            : 12'($urandom_range(0, 4095));
            frame_start  = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 7) == 0) channel_select = 2'($urandom_range(0, 3));
            model_step();
            @(posedge clk);
            #1;
            check($sformatf("rand%0d_val", n), int'(val), m_val);
            check($sformatf("rand%0d_busy", n), int'(busy), m_busy);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/level_meter.md
LEVEL_METER -- requirements
Module: level_meter

Interface
REQ-001 SHALL have parameter DECAY_SHIFT, default 4: per-frame display decay is disp >> DECAY_SHIFT.
REQ-002 SHALL have parameter MIDSCALE, default 2048: ADC code treated as zero amplitude.
REQ-003 SHALL have port clk, input, 1: rising-edge clock; pixel clock domain.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port sample_valid, input, 1: qualifies sample_ch and sample_data for one cycle.
REQ-006 SHALL have port sample_ch, input, 2: channel index of the current sample.
REQ-007 SHALL have port sample_data, input, 12: unsigned offset-binary ADC code.
REQ-008 SHALL have port frame_start, input, 1: one-cycle pulse from video timing at the first active line of each frame.
REQ-009 SHALL have port channel_select, input, 2: channel whose level drives val.
REQ-010 SHALL have port val, output, 12: display level 0..2047 for the selected channel, feeding the pixel-colour stage.
REQ-011 SHALL have port busy, output, 1: high while the UPDATE state is active.

Function
REQ-012 SHALL compute dev = |sample_data - MIDSCALE| at 13-bit width, clamped to 2047 (e.g. sample 0 -> 2047, 4095 -> 2047).
REQ-013 SHALL keep a per-channel peak[4] register that takes max(peak, dev) on each sample_valid for sample_ch.
REQ-014 On frame_start in ACCUM, SHALL copy peak[0..3] to snap[0..3] and clear peak[0..3] in the same cycle.
REQ-015 A sample valid in the frame_start cycle SHALL load its channel's cleared peak with dev (counts toward the new frame), not snap.
REQ-016 FSM states: ACCUM (reset state) and UPDATE.
  - ACCUM -> UPDATE on frame_start.
  - UPDATE holds for exactly 4 cycles with channel index i = 0..3, then returns to ACCUM.
REQ-017 In UPDATE step i, SHALL set disp[i] = max(snap[i], disp[i] - (disp[i] >> DECAY_SHIFT)).
REQ-018 frame_start arriving during UPDATE SHALL be ignored: no snapshot, no restart.
REQ-019 sample_valid during UPDATE SHALL accumulate into peak[] normally.
REQ-020 val SHALL be registered as disp[channel_select], with 1-cycle latency from a channel_select or disp change.
REQ-021 Worst case, val SHALL reflect a new frame's result 5 cycles after frame_start.
REQ-022 disp SHALL decay monotonically to 0 with no underflow; disp = 1..15 with shift 4 stays unchanged unless snap is larger (accepted floor behaviour).
REQ-023 All arithmetic SHALL be unsigned with no wrap-around; peak, snap and disp are 11-bit values held in 12-bit registers.

Reset
REQ-024 While rst is high, SHALL clear peak[], snap[] and disp[], drive val = 0 and busy = 0, and enter ACCUM.
REQ-025 rst asserted mid-UPDATE SHALL abort the update; no partial disp values SHALL survive reset.
REQ-026 The first frame_start after reset SHALL be processed normally.

Structure
REQ-027 NUM_CH = 4, SAMPLE_W = 12, LEVEL_MAX = 2047 and the FSM state encoding SHALL live in the shared package audio_pkg.
REQ-028 The max/decay arithmetic of REQ-017 SHALL be one combinational sub-module, level_decay, instantiated once and time-shared across channels via index i.
REQ-029 The implementation SHALL be a single clock domain with no latches; every output SHALL be driven from a flop.

Verification
REQ-030 Reset check: hold rst 3 cycles mid-UPDATE -> val = 0, busy = 0; the next frame_start with no samples leaves val = 0.
REQ-031 Full-scale peak: ch0 samples 1000, 3500, 2048, then frame_start with channel_select = 0 -> val = 1452 within 5 cycles.
REQ-032 Decay: disp[1] = 1600, frame with no ch1 samples -> val = 1500; the next empty frame -> 1407.
REQ-033 Clamp and select: ch2 sample 0, ch3 sample 4095, frame_start, then channel_select toggles 2 -> 3 -> both read val = 2047; ch0 reads val = 0.
REQ-034 Boundary coincidence: ch0 sample 3000 in the frame_start cycle -> the current frame's snap excludes it; the following frame_start gives val = 952.
REQ-035 Ignored pulse: second frame_start 2 cycles after the first -> busy stays high exactly 4 cycles and disp is updated once.
